// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius game datapath: game-wide constants,
// the sequence-player state encoding and the colour-symbol decoder.
package genius_pkg;

  localparam int unsigned SYM_W    = 2;
  localparam int unsigned N_ROUNDS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ON,
    ST_OFF,
    ST_DONE
  } player_state_t;

  // Colour symbol to one-hot LED pattern; also used by the user-entry comparator.
  function automatic logic [2**SYM_W-1:0] sym2onehot(input logic [SYM_W-1:0] sym);
    logic [2**SYM_W-1:0] oh;
    oh      = '0;
    oh[sym] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/seq_player_if.sv
// Bundle between the sequence player, the game controller (start/level,
// busy/end_FPGA), the sequence RAM (seq_addr/seq_data) and the LED outputs.
interface seq_player_if #(
  parameter int unsigned N_ROUNDS = 16,
  parameter int unsigned SYM_W    = 2
);

  localparam int unsigned ADDR_W = $clog2(N_ROUNDS);
  localparam int unsigned LVL_W  = ADDR_W + 1;

  logic                  start;
  logic [LVL_W-1:0]      level;
  logic [ADDR_W-1:0]     seq_addr;
  logic [SYM_W-1:0]      seq_data;
  logic [2**SYM_W-1:0]   leds;
  logic                  busy;
  logic                  end_FPGA;

  // Controller/RAM side.
  modport master (
    output start, level, seq_data,
    input  seq_addr, leds, busy, end_FPGA
  );

  // Player side.
  modport slave (
    input  start, level, seq_data,
    output seq_addr, leds, busy, end_FPGA
  );

endinterface

// File: rtl/seq_player_tick_timer.sv
// Loadable down-counter. A load of N raises done on the Nth cycle after the
// load edge, so an action taken at the next edge follows exactly N cycles.
module tick_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  // Load wins over counting; count rests at zero once expired.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/seq_player.sv
// Genius sequence player: on start, reads lvl symbols from the sequence RAM
// and shows each on the LEDs for ON_CYCLES followed by an OFF_CYCLES dark gap,
// then pulses end_FPGA for one cycle.
module seq_player #(
  parameter int unsigned N_ROUNDS   = genius_pkg::N_ROUNDS,
  parameter int unsigned SYM_W      = genius_pkg::SYM_W,
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned OFF_CYCLES = 12_500_000
) (
  input logic          CLOCK_50,
  input logic          reset,
  seq_player_if.slave  bus
);

  import genius_pkg::*;

  localparam int unsigned ADDR_W  = $clog2(N_ROUNDS);
  localparam int unsigned LVL_W   = ADDR_W + 1;
  localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0]    ON_TV  = TW'(ON_CYCLES);
  localparam logic [TW-1:0]    OFF_TV = TW'(OFF_CYCLES);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_ROUNDS);

  player_state_t     state, state_next;
  logic [LVL_W-1:0]  lvl;
  logic [LVL_W-1:0]  level_clamped;
  logic [ADDR_W-1:0] idx;
  logic              last_sym;

  logic              capture;
  logic              addr_first;
  logic              addr_next;
  logic              leds_set;
  logic              leds_clear;
  logic              tmr_load;
  logic [TW-1:0]     tmr_value;
  logic              tmr_done;

  assign level_clamped = (bus.level > LVL_MAX) ? LVL_MAX : bus.level;
  assign last_sym      = ({1'b0, idx} == (lvl - LVL_W'(1)));

  tick_timer #(
    .W (TW)
  ) u_timer (
    .clk   (CLOCK_50),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    addr_first = 1'b0;
    addr_next  = 1'b0;
    leds_set   = 1'b0;
    leds_clear = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          if (level_clamped == '0) begin
            state_next = ST_DONE;
          end else begin
            addr_first = 1'b1;
            state_next = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        state_next = ST_DATA;
      end
      ST_DATA: begin
        leds_set   = 1'b1;
        tmr_load   = 1'b1;
        tmr_value  = ON_TV;
        state_next = ST_ON;
      end
      ST_ON: begin
        if (tmr_done) begin
          leds_clear = 1'b1;
          tmr_load   = 1'b1;
          tmr_value  = OFF_TV;
          state_next = ST_OFF;
        end
      end
      ST_OFF: begin
        if (tmr_done) begin
          if (last_sym) begin
            state_next = ST_DONE;
          end else begin
            addr_next  = 1'b1;
            state_next = ST_ADDR;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Level capture, symbol index, RAM address and LED register. The address is
  // loaded on entry to ADDR so the RAM samples it at the ADDR->DATA edge and
  // its data is ready to be decoded at the DATA->ON edge.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      lvl          <= '0;
      idx          <= '0;
      bus.seq_addr <= '0;
      bus.leds     <= '0;
    end else begin
      if (capture) begin
        lvl <= level_clamped;
      end
      if (addr_first) begin
        idx          <= '0;
        bus.seq_addr <= '0;
      end else if (addr_next) begin
        idx          <= idx + ADDR_W'(1);
        bus.seq_addr <= idx + ADDR_W'(1);
      end
      if (leds_set) begin
        bus.leds <= sym2onehot(bus.seq_data);
      end else if (leds_clear) begin
        bus.leds <= '0;
      end
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.end_FPGA = (state == ST_DONE);

endmodule
